part_1_init_xchg: RTL

Initiator-side data-exchange controller, the receiving end of the target's per-mission-clock put stream. On each mission-clock edge request it freezes all mission clocks and collects one 9-bit payload per active clock channel from the transport. It then drives the payloads onto the partition's download ports (wen/i_data) and upload mirror ports, and releases the clocks. It sits between the mission clock generator and the fringe transport adapter on the initiator partition.

---
 rtl/part_1_init_xchg_if.sv | 13 +
 rtl/part_1_init_xchg.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/part_1_init_xchg_if.sv
// Transport beat channel between the fringe transport adapter (master) and the
// initiator exchange controller (slave).
interface part_1_init_xchg_if #(
  parameter int DW = 9
);
  logic          rx_valid;
  logic          rx_ready;
  logic [1:0]    rx_chan;
  logic [DW-1:0] rx_data;

  modport master (output rx_valid, output rx_chan, output rx_data, input rx_ready);
  modport slave  (input rx_valid, input rx_chan, input rx_data, output rx_ready);
endinterface

// File: rtl/part_1_init_xchg.sv
// Initiator-side exchange controller: freezes the mission clocks on an edge request,
// collects one payload per requested channel, drives them out and releases the clocks.
module part_1_init_xchg #(
  parameter int N_CLK    = 4,
  parameter int DW       = 9,
  parameter int WDOG_MAX = 1000,
  parameter int WDOG_W   = 16
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic [N_CLK-1:0]  edge_i,
  part_1_init_xchg_if.slave rx_if,
  output logic [N_CLK-1:0]  freeze_clk_o,
  output logic              wen0_o,
  output logic              wen1_o,
  output logic              wen2_o,
  output logic [7:0]        i_data0_o,
  output logic [7:0]        i_data1_o,
  output logic [7:0]        i_data2_o,
  output logic              up_valid_o,
  output logic [7:0]        up_data_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_dup_o,
  output logic              err_unexp_o,
  output logic              err_wdog_o
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_APPLY   = 2'd2
  } state_t;

  // The last COLLECT cycle is the one whose incremented count reaches WDOG_MAX-1.
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_MAX - 1);

  state_t            r_state;
  logic [N_CLK-1:0]  r_exp;
  logic [N_CLK-1:0]  r_got;
  logic [N_CLK-1:0]  r_pend;
  logic [N_CLK-1:0]  r_freeze;
  logic [DW-1:0]     r_buf [N_CLK];
  logic [DW-1:0]     r_out [N_CLK];
  logic [WDOG_W-1:0] r_wdog;
  logic              r_done;
  logic              r_err_dup;
  logic              r_err_unexp;
  logic              r_err_wdog;

  logic              w_accept;
  logic              w_take;
  logic              w_dup;
  logic              w_unexp;
  logic              w_complete;
  logic              w_timeout;
  logic [N_CLK-1:0]  w_chan_bit;
  logic [N_CLK-1:0]  w_got_nxt;
  logic [N_CLK-1:0]  w_trigger;
  logic [WDOG_W-1:0] w_wdog_nxt;

  // NOTE: every signal gets a default before any condition, so no path can infer a latch.
  always_comb begin
    w_chan_bit                = '0;
    w_chan_bit[rx_if.rx_chan] = 1'b1;
    w_accept   = rx_if.rx_valid && (r_state == ST_COLLECT);
    w_take     = w_accept && r_exp[rx_if.rx_chan] && !r_got[rx_if.rx_chan];
    w_dup      = w_accept && r_got[rx_if.rx_chan];
    w_unexp    = w_accept && !r_exp[rx_if.rx_chan];
    w_got_nxt  = r_got | (w_take ? w_chan_bit : '0);
    w_complete = (w_got_nxt == r_exp);
    w_wdog_nxt = r_wdog + 1'b1;
    w_timeout  = (w_wdog_nxt == WDOG_LAST);
    w_trigger  = edge_i | r_pend;
  end

  // NOTE: all state updates use <= so every branch sees the start-of-cycle values.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state     <= ST_IDLE;
      r_exp       <= '0;
      r_got       <= '0;
      r_pend      <= '0;
      r_freeze    <= '0;
      r_wdog      <= '0;
      r_done      <= 1'b0;
      r_err_dup   <= 1'b0;
      r_err_unexp <= 1'b0;
      r_err_wdog  <= 1'b0;
      // NOTE: the payload buffers are four small registers feeding outputs, not a RAM,
      // so they are reset along with everything else.
      for (int n = 0; n < N_CLK; n++) begin
        r_buf[n] <= '0;
        r_out[n] <= '0;
      end
    end else begin
      r_done <= 1'b0;
      if (r_state != ST_IDLE) begin
        r_pend <= r_pend | edge_i;
      end

      case (r_state)
        ST_IDLE: begin
          if (|w_trigger) begin
            r_exp    <= w_trigger;
            r_pend   <= '0;
            r_got    <= '0;
            r_wdog   <= '0;
            r_freeze <= '1;
            r_state  <= ST_COLLECT;
          end
        end

        ST_COLLECT: begin
          if (w_take) begin
            r_buf[rx_if.rx_chan] <= rx_if.rx_data;
          end
          if (w_dup) begin
            r_err_dup <= 1'b1;
          end
          if (w_unexp) begin
            r_err_unexp <= 1'b1;
          end
          r_got  <= w_got_nxt;
          r_wdog <= w_wdog_nxt;
          // A beat completing the set wins over a timeout in the same cycle.
          if (w_complete) begin
            r_state <= ST_APPLY;
          end else if (w_timeout) begin
            r_err_wdog <= 1'b1;
            r_state    <= ST_APPLY;
          end
        end

        ST_APPLY: begin
          for (int n = 0; n < N_CLK; n++) begin
            if (r_got[n]) begin
              r_out[n] <= r_buf[n];
            end
          end
          r_freeze <= '0;
          r_done   <= 1'b1;
          r_state  <= ST_IDLE;
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign rx_if.rx_ready = (r_state == ST_COLLECT);
  assign busy_o         = (r_state != ST_IDLE);
  assign freeze_clk_o   = r_freeze;
  assign done_o         = r_done;
  assign err_dup_o      = r_err_dup;
  assign err_unexp_o    = r_err_unexp;
  assign err_wdog_o     = r_err_wdog;

  assign {wen0_o, i_data0_o}     = r_out[0];
  assign {wen1_o, i_data1_o}     = r_out[1];
  assign {wen2_o, i_data2_o}     = r_out[2];
  assign {up_valid_o, up_data_o} = r_out[3];

endmodule
